// File: rtl/vec_issue_ctrl.sv
// vec_issue_ctrl: accepts instruction/operand triples from the scalar core into
// a small FIFO, issues them one at a time to the vector datapath, waits for
// completion and returns a response over the ack/ready handshake.
module vec_issue_ctrl #(
  parameter int XLEN   = 32,
  parameter int QDEPTH = 2,
  parameter int CNTW   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inst_valid,
  input  logic [XLEN-1:0] instruction,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            vec_pro_ready,
  input  logic            scalar_pro_ready,
  output logic            vec_pro_ack,
  output logic            resp_illegal,
  output logic            issue_valid,
  output logic [XLEN-1:0] issue_inst,
  output logic [XLEN-1:0] issue_rs1,
  output logic [XLEN-1:0] issue_rs2,
  input  logic            is_vec,
  input  logic            dp_done,
  output logic            busy,
  output logic [CNTW-1:0] retired_cnt
);

  localparam int PW = $clog2(QDEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, EXEC, RESP} state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] fifo_inst [0:QDEPTH-1];
  logic [XLEN-1:0] fifo_rs1  [0:QDEPTH-1];
  logic [XLEN-1:0] fifo_rs2  [0:QDEPTH-1];
  logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]     count_reg;
  logic [XLEN-1:0] issue_inst_reg, issue_rs1_reg, issue_rs2_reg;
  logic            resp_illegal_reg;
  logic [CNTW-1:0] retired_reg;
  logic            push, pop;

  // Readiness comes from the registered count only; a same-cycle pop never
  // frees a slot early.
  assign vec_pro_ready = (count_reg != (PW+1)'(QDEPTH));
  assign push          = inst_valid && vec_pro_ready;

  assign issue_inst   = issue_inst_reg;
  assign issue_rs1    = issue_rs1_reg;
  assign issue_rs2    = issue_rs2_reg;
  assign resp_illegal = resp_illegal_reg;
  assign retired_cnt  = retired_reg;

  // FIFO storage: no reset needed, the pointers alone define valid entries.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst[wr_ptr_reg] <= instruction;
      fifo_rs1[wr_ptr_reg]  <= rs1_data;
      fifo_rs2[wr_ptr_reg]  <= rs2_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (PW+1)'(1);
        2'b01:   count_reg <= count_reg - (PW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic, pop request and handshake outputs.
  always_comb begin
    state_next  = state_reg;
    pop         = 1'b0;
    issue_valid = 1'b0;
    vec_pro_ack = 1'b0;
    busy        = (state_reg != IDLE) || (count_reg != '0);
    case (state_reg)
      IDLE: begin
        if (count_reg != '0) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        issue_valid = 1'b1;
        state_next  = is_vec ? EXEC : RESP;
      end
      EXEC: begin
        if (dp_done) state_next = RESP;
      end
      RESP: begin
        vec_pro_ack = 1'b1;
        if (scalar_pro_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Issue registers load the FIFO head on pop and hold until the next pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_inst_reg <= '0;
      issue_rs1_reg  <= '0;
      issue_rs2_reg  <= '0;
    end else if (pop) begin
      issue_inst_reg <= fifo_inst[rd_ptr_reg];
      issue_rs1_reg  <= fifo_rs1[rd_ptr_reg];
      issue_rs2_reg  <= fifo_rs2[rd_ptr_reg];
    end
  end

  // Illegal flag captures the decoder verdict in ISSUE and holds until the next ISSUE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  resp_illegal_reg <= 1'b0;
    else if (state_reg == ISSUE) resp_illegal_reg <= ~is_vec;
  end

  // Retire counter advances on each completed response handshake and wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                    retired_reg <= '0;
    else if (state_reg == RESP && scalar_pro_ready) retired_reg <= retired_reg + CNTW'(1);
  end

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// Testbench for vec_issue_ctrl: scoreboard of accepted instructions checked at
// issue, plus a cycle-level protocol model checked every cycle.
module tb_vec_issue_ctrl;

  localparam int XL = 32;
  localparam int QD = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          inst_valid;
  logic [XL-1:0] instruction, rs1_data, rs2_data;
  logic          vec_pro_ready;
  logic          scalar_pro_ready;
  logic          vec_pro_ack;
  logic          resp_illegal;
  logic          issue_valid;
  logic [XL-1:0] issue_inst, issue_rs1, issue_rs2;
  logic          is_vec;
  logic          dp_done;
  logic          busy;
  logic [CW-1:0] retired_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [XL-1:0] inst;
    logic [XL-1:0] rs1;
    logic [XL-1:0] rs2;
  } ent_t;

  ent_t sb[$];

  vec_issue_ctrl #(.XLEN(XL), .QDEPTH(QD), .CNTW(CW)) dut (
    .clk(clk), .reset(reset), .inst_valid(inst_valid), .instruction(instruction),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .vec_pro_ready(vec_pro_ready),
    .scalar_pro_ready(scalar_pro_ready), .vec_pro_ack(vec_pro_ack),
    .resp_illegal(resp_illegal), .issue_valid(issue_valid), .issue_inst(issue_inst),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .is_vec(is_vec), .dp_done(dp_done),
    .busy(busy), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  // Decoder stand-in: vector opcode is 7'h57.
  assign is_vec = (issue_inst[6:0] == 7'h57);

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Datapath and scalar-side responders.
  int dp_delay   = 1;
  int dp_wait    = 0;
  bit dp_hold    = 0;
  bit dp_noise   = 0;
  bit srdy_rand  = 0;
  bit srdy_level = 1;

  always @(posedge clk) begin
    #2;
    if (!reset) begin
      dp_wait = 0;
      dp_done = 1'b0;
    end else begin
      dp_done = dp_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (issue_valid && is_vec) dp_wait = dp_delay;
      else if (dp_wait > 0 && !dp_hold) begin
        dp_wait--;
        if (dp_wait == 0) dp_done = 1'b1;
      end
    end
    scalar_pro_ready = srdy_rand ? ($urandom_range(0, 2) != 0) : srdy_level;
  end

  // Protocol model: checks DUT outputs each cycle, then advances on the
  // input values that the next rising edge will see.
  localparam int P_IDLE = 0, P_ISSUE = 1, P_EXEC = 2, P_RESP = 3;
  int            ph = P_IDLE;
  ent_t          cur = '0;
  logic          cur_ill = 1'b0;
  logic [CW-1:0] exp_ret = '0;
  logic          acc;
  ent_t          e;

  always @(negedge clk) begin
    if (!reset) begin
      sb.delete();
      ph      = P_IDLE;
      cur     = '0;
      cur_ill = 1'b0;
      exp_ret = '0;
      check_eq("rst_ready", 64'(vec_pro_ready), 64'(1));
      check_eq("rst_ack", 64'(vec_pro_ack), 64'(0));
      check_eq("rst_issue_valid", 64'(issue_valid), 64'(0));
      check_eq("rst_illegal", 64'(resp_illegal), 64'(0));
      check_eq("rst_busy", 64'(busy), 64'(0));
      check_eq("rst_retired", 64'(retired_cnt), 64'(0));
      check_eq("rst_issue_inst", 64'(issue_inst), 64'(0));
    end else begin
      check_eq("ready", 64'(vec_pro_ready), 64'(sb.size() != QD));
      check_eq("issue_valid", 64'(issue_valid), 64'(ph == P_ISSUE));
      check_eq("ack", 64'(vec_pro_ack), 64'(ph == P_RESP));
      check_eq("busy", 64'(busy), 64'(ph != P_IDLE || sb.size() != 0));
      check_eq("retired", 64'(retired_cnt), 64'(exp_ret));
      check_eq("issue_inst", 64'(issue_inst), 64'(cur.inst));
      check_eq("issue_rs1", 64'(issue_rs1), 64'(cur.rs1));
      check_eq("issue_rs2", 64'(issue_rs2), 64'(cur.rs2));
      check_eq("illegal", 64'(resp_illegal), 64'(cur_ill));
      acc = inst_valid && (sb.size() != QD);
      case (ph)
        P_IDLE:  if (sb.size() != 0) begin cur = sb.pop_front(); ph = P_ISSUE; end
        P_ISSUE: begin
          cur_ill = (cur.inst[6:0] != 7'h57);
          ph      = cur_ill ? P_RESP : P_EXEC;
        end
        P_EXEC:  if (dp_done) ph = P_RESP;
        default: if (scalar_pro_ready) begin exp_ret = exp_ret + 1'b1; ph = P_IDLE; end
      endcase
      if (acc) begin
        e.inst = instruction;
        e.rs1  = rs1_data;
        e.rs2  = rs2_data;
        sb.push_back(e);
      end
    end
  end

  task automatic push_inst(input logic [XL-1:0] i, input logic [XL-1:0] r1, input logic [XL-1:0] r2);
    bit done = 0;
    @(posedge clk); #1;
    inst_valid  = 1'b1;
    instruction = i;
    rs1_data    = r1;
    rs2_data    = r2;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      done = vec_pro_ready;
      @(posedge clk); #1;
    end
    inst_valid = 1'b0;
    $display("push inst=%08h rs1=%08h rs2=%08h accepted=%0d", i, r1, r2, done);
    if (!done) check_eq("push_accept", 64'(done), 64'(1));
  endtask

  task automatic wait_idle();
    bit idle = 0;
    for (int n = 0; n < 500 && !idle; n++) begin
      @(negedge clk);
      idle = !busy;
    end
    if (!idle) check_eq("idle_timeout", 64'(idle), 64'(1));
  endtask

  task automatic wait_ack();
    bit seen = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      seen = vec_pro_ack;
    end
    if (!seen) check_eq("ack_timeout", 64'(seen), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; inst_valid = 1'b0; instruction = '0; rs1_data = '0; rs2_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Single legal op, dp_done in third EXEC cycle.
    dp_delay = 3;
    push_inst(32'h0200_0057, 32'd16, 32'd5);
    wait_idle();
    check_eq("single_rs1", 64'(issue_rs1), 64'(16));
    check_eq("single_retired", 64'(retired_cnt), 64'(1));

    // Illegal op: response held while dp_done toggles randomly.
    srdy_level = 1'b0;
    dp_noise   = 1'b1;
    push_inst(32'h0000_0013, 32'd7, 32'd9);
    wait_ack();
    repeat (4) @(posedge clk);
    #1 srdy_level = 1'b1;
    wait_idle();
    dp_noise = 1'b0;
    check_eq("illegal_flag", 64'(resp_illegal), 64'(1));

    // Backpressure: first op stuck in EXEC, two queued fill the FIFO.
    dp_delay = 1;
    dp_hold  = 1'b1;
    push_inst(32'h0000_1057, 32'h11, 32'h12);
    push_inst(32'h0000_2057, 32'h21, 32'h22);
    push_inst(32'h0000_3013, 32'h31, 32'h32);
    check_eq("bp_full", 64'(vec_pro_ready), 64'(0));
    fork
      push_inst(32'h0000_4057, 32'h41, 32'h42);
      begin
        repeat (5) @(posedge clk);
        #1 dp_hold = 1'b0;
      end
    join
    wait_idle();

    // Response stall then random response readiness over 8 instructions.
    srdy_level = 1'b0;
    dp_delay   = 2;
    fork
      for (int k = 0; k < 8; k++)
        push_inst({25'(k + 1), ((k % 2) == 0) ? 7'h57 : 7'h13}, $urandom, $urandom);
      begin
        wait_ack();
        repeat (10) @(posedge clk);
        #1;
        check_eq("stall_ack_held", 64'(vec_pro_ack), 64'(1));
        srdy_level = 1'b1;
        @(posedge clk); #1 srdy_rand = 1'b1;
      end
    join
    wait_idle();
    srdy_rand  = 1'b0;
    srdy_level = 1'b1;
    @(posedge clk);

    // Reset in EXEC with two queued entries.
    dp_hold = 1'b1;
    push_inst(32'h0000_5057, 32'h51, 32'h52);
    push_inst(32'h0000_6057, 32'h61, 32'h62);
    push_inst(32'h0000_7057, 32'h71, 32'h72);
    check_eq("pre_reset_busy", 64'(busy), 64'(1));
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check_eq("async_busy", 64'(busy), 64'(0));
    check_eq("async_ready", 64'(vec_pro_ready), 64'(1));
    check_eq("async_ack", 64'(vec_pro_ack), 64'(0));
    check_eq("async_issue_inst", 64'(issue_inst), 64'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    dp_hold = 1'b0;
    push_inst(32'h0000_8057, 32'h81, 32'h82);
    wait_idle();
    check_eq("post_reset_inst", 64'(issue_inst), 64'(32'h0000_8057));

    // Counter wrap: 17 completions since reset leaves 1 in a 4-bit counter.
    for (int k = 0; k < 16; k++) begin
      push_inst({25'(k + 100), 7'h13}, 32'(k), 32'(k + 1));
      wait_idle();
    end
    check_eq("wrap_retired", 64'(retired_cnt), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
